// File: rtl/mem_if_pkg.sv
// Shared constants and types for the 16-bit single-port memory and its initiator.
package mem_if_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 9;
   localparam int LEN_W  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      RD_TAIL = 2'd2,
      WR      = 2'd3
   } state_t;

   typedef logic [LEN_W-1:0] burst_len_t;
endpackage

// File: rtl/mem_master.sv
// CPU-side memory initiator: 1-cycle writes, pipelined burst reads (beat k after edge k+2 of accept).
// Ready only in IDLE; response path has no backpressure, read beats stream back gap-free.
module mem_master
   import mem_if_pkg::*;
#(
   parameter int DATA_W = mem_if_pkg::DATA_W,
   parameter int ADDR_W = mem_if_pkg::ADDR_W,
   parameter int LEN_W  = mem_if_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [LEN_W-1:0]  cpu_burst_len,
   output logic              cpu_rsp_valid,
   output logic [DATA_W-1:0] cpu_rsp_data,
   output logic              cpu_rsp_last,
   output logic              cpu_wr_ack,
   output logic              mem_rn,
   output logic              mem_wn,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   state_t            state_q;
   logic              mem_rn_q, mem_wn_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_din_q;
   logic [LEN_W-1:0]  issue_cnt_q, cap_cnt_q;
   logic              cap_vld_q;
   logic              rsp_valid_q, rsp_last_q, wr_ack_q;
   logic [DATA_W-1:0] rsp_data_q;

   logic [ADDR_W-1:0] addr_inc_d;
   logic              issue_done_d, cap_final_d;

   always_comb begin
      addr_inc_d   = mem_addr_q + 1'b1;
      issue_done_d = (issue_cnt_q == '0);
      cap_final_d  = (cap_cnt_q == '0);
   end

   // cap_vld_q marks that the memory sampled mem_rn at the previous edge,
   // so mem_dout holds a fresh word to capture at this edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_rn_q    <= 1'b0;
         mem_wn_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         issue_cnt_q <= '0;
         cap_cnt_q   <= '0;
         cap_vld_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
         wr_ack_q    <= 1'b0;
      end else begin
         cap_vld_q <= mem_rn_q;
         wr_ack_q  <= 1'b0;

         if (cap_vld_q) begin
            rsp_data_q  <= mem_dout;
            rsp_valid_q <= 1'b1;
            rsp_last_q  <= cap_final_d;
            if (!cap_final_d)
               cap_cnt_q <= cap_cnt_q - 1'b1;
         end else begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (cpu_req_valid) begin
                  mem_addr_q <= cpu_addr;
                  if (cpu_we) begin
                     state_q   <= WR;
                     mem_wn_q  <= 1'b1;
                     mem_din_q <= cpu_wdata;
                  end else begin
                     state_q     <= RD;
                     mem_rn_q    <= 1'b1;
                     issue_cnt_q <= cpu_burst_len;
                     cap_cnt_q   <= cpu_burst_len;
                  end
               end
            end
            WR: begin
               mem_wn_q <= 1'b0;
               wr_ack_q <= 1'b1;
               state_q  <= IDLE;
            end
            RD: begin
               if (issue_done_d) begin
                  mem_rn_q <= 1'b0;
                  state_q  <= RD_TAIL;
               end else begin
                  mem_addr_q  <= addr_inc_d;
                  issue_cnt_q <= issue_cnt_q - 1'b1;
               end
            end
            RD_TAIL: begin
               if (cap_vld_q && cap_final_d)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_req_ready = (state_q == IDLE);
   assign cpu_rsp_valid = rsp_valid_q;
   assign cpu_rsp_data  = rsp_data_q;
   assign cpu_rsp_last  = rsp_last_q;
   assign cpu_wr_ack    = wr_ack_q;
   assign mem_rn        = mem_rn_q;
   assign mem_wn        = mem_wn_q;
   assign mem_addr      = mem_addr_q;
   assign mem_din       = mem_din_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a registered-read memory model.
module tb_mem_master;
   import mem_if_pkg::*;

   logic              clk;
   logic              reset;
   logic              cpu_req_valid;
   logic              cpu_req_ready;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   burst_len_t        cpu_burst_len;
   logic              cpu_rsp_valid;
   logic [DATA_W-1:0] cpu_rsp_data;
   logic              cpu_rsp_last;
   logic              cpu_wr_ack;
   logic              mem_rn;
   logic              mem_wn;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   int checks = 0;
   int errors = 0;

   mem_master dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_req_valid (cpu_req_valid),
      .cpu_req_ready (cpu_req_ready),
      .cpu_we        (cpu_we),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_burst_len (cpu_burst_len),
      .cpu_rsp_valid (cpu_rsp_valid),
      .cpu_rsp_data  (cpu_rsp_data),
      .cpu_rsp_last  (cpu_rsp_last),
      .cpu_wr_ack    (cpu_wr_ack),
      .mem_rn        (mem_rn),
      .mem_wn        (mem_wn),
      .mem_addr      (mem_addr),
      .mem_din       (mem_din),
      .mem_dout      (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wn) mem[mem_addr] <= mem_din;
      if (mem_rn) mem_dout <= mem[mem_addr];
   end

   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         assert (!(mem_rn && mem_wn)) else begin
            errors++;
            $error("FAIL rn_wn_excl observed rn=%0b wn=%0b expected not both", mem_rn, mem_wn);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
      cpu_req_valid = 1'b1;
      cpu_we        = we;
      cpu_addr      = a;
      cpu_wdata     = d;
      cpu_burst_len = l;
   endtask

   logic [ADDR_W-1:0] b_addr [0:3];
   logic [DATA_W-1:0] b_data [0:3];
   int stray;

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 16'h8000 | 16'(i);
      mem[9'h005] <= 16'h1234;
      mem[9'h1FE] <= 16'hA001;
      mem[9'h1FF] <= 16'hA002;
      mem[9'h000] <= 16'hA003;
      mem[9'h001] <= 16'hA004;
      mem_dout <= '0;
      b_addr[0] = 9'h1FE; b_addr[1] = 9'h1FF; b_addr[2] = 9'h000; b_addr[3] = 9'h001;
      b_data[0] = 16'hA001; b_data[1] = 16'hA002; b_data[2] = 16'hA003; b_data[3] = 16'hA004;

      reset = 1'b1;
      cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_burst_len = '0;
      #12;
      chk("rst_ready", 32'(cpu_req_ready), 32'd1);
      chk("rst_rn", 32'(mem_rn), 32'd0);
      chk("rst_wn", 32'(mem_wn), 32'd0);
      chk("rst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
      chk("rst_rsp_last", 32'(cpu_rsp_last), 32'd0);
      chk("rst_wr_ack", 32'(cpu_wr_ack), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_din", 32'(mem_din), 32'd0);
      chk("rst_rsp_data", 32'(cpu_rsp_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // single read, len 0
      req(1'b0, 9'h005, 16'h0, 4'd0);
      tick();
      chk("rd1_rn", 32'(mem_rn), 32'd1);
      chk("rd1_addr", 32'(mem_addr), 32'h005);
      chk("rd1_busy", 32'(cpu_req_ready), 32'd0);
      cpu_req_valid = 1'b0;
      tick();
      chk("rd1_rn_off", 32'(mem_rn), 32'd0);
      chk("rd1_early", 32'(cpu_rsp_valid), 32'd0);
      tick();
      chk("rd1_valid", 32'(cpu_rsp_valid), 32'd1);
      chk("rd1_last", 32'(cpu_rsp_last), 32'd1);
      chk("rd1_data", 32'(cpu_rsp_data), 32'h1234);
      chk("rd1_ready", 32'(cpu_req_ready), 32'd1);
      tick();
      chk("rd1_valid_off", 32'(cpu_rsp_valid), 32'd0);
      chk("rd1_data_hold", 32'(cpu_rsp_data), 32'h1234);

      // write then read back
      req(1'b1, 9'h010, 16'h5A5A, 4'd0);
      tick();
      chk("wr_wn", 32'(mem_wn), 32'd1);
      chk("wr_addr", 32'(mem_addr), 32'h010);
      chk("wr_din", 32'(mem_din), 32'h5A5A);
      chk("wr_ack_early", 32'(cpu_wr_ack), 32'd0);
      cpu_req_valid = 1'b0;
      tick();
      chk("wr_wn_off", 32'(mem_wn), 32'd0);
      chk("wr_ack", 32'(cpu_wr_ack), 32'd1);
      chk("wr_ready", 32'(cpu_req_ready), 32'd1);
      tick();
      chk("wr_ack_pulse", 32'(cpu_wr_ack), 32'd0);
      req(1'b0, 9'h010, 16'h0, 4'd0);
      tick();
      cpu_req_valid = 1'b0;
      tick();
      tick();
      chk("rb_valid", 32'(cpu_rsp_valid), 32'd1);
      chk("rb_data", 32'(cpu_rsp_data), 32'h5A5A);
      tick();

      // wrapping burst, 4 beats
      req(1'b0, 9'h1FE, 16'h0, 4'd3);
      for (int k = 1; k <= 6; k++) begin
         tick();
         cpu_req_valid = 1'b0;
         if (k <= 4) begin
            chk($sformatf("bst_rn%0d", k), 32'(mem_rn), 32'd1);
            chk($sformatf("bst_addr%0d", k), 32'(mem_addr), 32'(b_addr[k-1]));
         end else begin
            chk($sformatf("bst_rn%0d", k), 32'(mem_rn), 32'd0);
         end
         if (k >= 3 && k <= 6) begin
            chk($sformatf("bst_valid%0d", k), 32'(cpu_rsp_valid), 32'd1);
            chk($sformatf("bst_data%0d", k), 32'(cpu_rsp_data), 32'(b_data[k-3]));
            chk($sformatf("bst_last%0d", k), 32'(cpu_rsp_last), (k == 6) ? 32'd1 : 32'd0);
         end else begin
            chk($sformatf("bst_valid%0d", k), 32'(cpu_rsp_valid), 32'd0);
         end
      end
      chk("bst_ready", 32'(cpu_req_ready), 32'd1);
      tick();
      chk("bst_end", 32'(cpu_rsp_valid), 32'd0);

      // valid held high: read len1, write (fields changed while busy), read back
      req(1'b0, 9'h005, 16'h0, 4'd1);
      tick();
      req(1'b1, 9'h030, 16'h2222, 4'd5);
      tick();
      chk("b2b_rn_e1", 32'(mem_rn), 32'd1);
      chk("b2b_addr_e1", 32'(mem_addr), 32'h006);
      req(1'b1, 9'h020, 16'h1111, 4'd5);
      tick();
      chk("b2b_v0", 32'(cpu_rsp_valid), 32'd1);
      chk("b2b_d0", 32'(cpu_rsp_data), 32'h1234);
      chk("b2b_busy", 32'(cpu_req_ready), 32'd0);
      tick();
      chk("b2b_d1", 32'(cpu_rsp_data), 32'h8006);
      chk("b2b_last", 32'(cpu_rsp_last), 32'd1);
      chk("b2b_ready", 32'(cpu_req_ready), 32'd1);
      tick();
      chk("b2b_wn", 32'(mem_wn), 32'd1);
      chk("b2b_waddr", 32'(mem_addr), 32'h020);
      chk("b2b_din", 32'(mem_din), 32'h1111);
      req(1'b0, 9'h020, 16'h0, 4'd0);
      tick();
      chk("b2b_ack", 32'(cpu_wr_ack), 32'd1);
      tick();
      chk("b2b_rn", 32'(mem_rn), 32'd1);
      chk("b2b_raddr", 32'(mem_addr), 32'h020);
      cpu_req_valid = 1'b0;
      tick();
      tick();
      chk("b2b_rdata", 32'(cpu_rsp_data), 32'h1111);
      chk("b2b_rlast", 32'(cpu_rsp_last), 32'd1);
      tick();

      // reset in the middle of an 8-beat burst
      req(1'b0, 9'h040, 16'h0, 4'd7);
      tick();
      cpu_req_valid = 1'b0;
      tick();
      tick();
      chk("abort_b0", 32'(cpu_rsp_data), 32'h8040);
      tick();
      tick();
      chk("abort_b2", 32'(cpu_rsp_data), 32'h8042);
      chk("abort_rn_pre", 32'(mem_rn), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_rn", 32'(mem_rn), 32'd0);
      chk("abort_valid", 32'(cpu_rsp_valid), 32'd0);
      chk("abort_last", 32'(cpu_rsp_last), 32'd0);
      chk("abort_ready", 32'(cpu_req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      stray = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (cpu_rsp_valid || cpu_wr_ack || mem_rn || mem_wn) stray++;
      end
      chk("abort_stray", 32'(stray), 32'd0);
      chk("abort_idle", 32'(cpu_req_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
